tpu_instr_buffer: RTL and testbench



---
 rtl/tpu_instr_buffer.sv | 151 +++++++++++++++
 tb/tb_tpu_instr_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_instr_buffer.sv
// Instruction RAM plus fetch streamer: stores words from the UART DMA and replays them over valid/ready.
// Optional build macro TPU_IBUF_WRITE_PROTECT_EN drops writes during a run and pulses wr_err instead.
module tpu_instr_buffer #(
    parameter int         DEPTH   = 32,
    parameter int         AW      = 5,
    parameter int         DW      = 32,
    parameter logic [7:0] HALT_OP = 8'hFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    output logic          instr_valid,
    output logic [DW-1:0] instr_data,
    output logic [AW-1:0] instr_addr,
    input  logic          instr_ready,
    output logic          busy,
    output logic          done,
    output logic          overrun,
    output logic          wr_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] rd_addr_s;
    logic          rd_en_s, wr_commit_s, accept_s, is_halt_s, at_end_s;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          valid_q, valid_d, busy_q, busy_d;
    logic          done_q, done_d, overrun_q, overrun_d, wr_err_q, wr_err_d;

    assign accept_s  = valid_q & instr_ready;
    assign is_halt_s = (rd_data_q[DW-1 -: 8] == HALT_OP);
    assign at_end_s  = (pc_q == AW'(DEPTH - 1));

    // Write gating: protected builds refuse writes while a run is in progress.
    always_comb begin
`ifdef TPU_IBUF_WRITE_PROTECT_EN
        wr_commit_s = wr_en & ~busy_q;
        wr_err_d    = wr_en & busy_q;
`else
        wr_commit_s = wr_en;
        wr_err_d    = 1'b0;
`endif
    end

    // Fetch sequencer next-state; the RAM is only read when a new word is needed so stalls hold data.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rd_en_s   = 1'b0;
        rd_addr_s = pc_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d   = ST_PRIME;
                    pc_d      = {AW{1'b0}};
                    rd_en_s   = 1'b1;
                    rd_addr_s = {AW{1'b0}};
                    busy_d    = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_PRIME: begin
                state_d = ST_STREAM;
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
            ST_STREAM: begin
                if (accept_s) begin
                    if (is_halt_s || at_end_s) begin
                        state_d   = ST_IDLE;
                        valid_d   = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        overrun_d = ~is_halt_s;
                    end else begin
                        pc_d      = pc_q + AW'(1);
                        rd_en_s   = 1'b1;
                        rd_addr_s = pc_q + AW'(1);
                    end
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
        if (rd_en_s) begin
            rd_data_d = mem[rd_addr_s];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // RAM array: never reset; the read above sees the pre-write word (read-first).
    always_ff @(posedge clk) begin
        if (wr_commit_s) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= {AW{1'b0}};
            rd_data_q <= {DW{1'b0}};
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rd_data_q <= rd_data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            wr_err_q  <= wr_err_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr_data  = rd_data_q;
    assign instr_addr  = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = overrun_q;
    assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_tpu_instr_buffer.sv
// Scoreboard bench for tpu_instr_buffer: expected words are queued at start and popped on each accept.
module tb_tpu_instr_buffer;

`ifdef TPU_IBUF_WRITE_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic        start = 1'b0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [4:0]  instr_addr;
    logic        instr_ready = 1'b1;
    logic        busy, done, overrun, wr_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] model [32];
    logic [4:0]  exp_addr_q [$];
    logic [31:0] exp_data_q [$];
    bit          exp_ovr;

    tpu_instr_buffer dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .instr_valid(instr_valid), .instr_data(instr_data),
        .instr_addr(instr_addr), .instr_ready(instr_ready), .busy(busy), .done(done),
        .overrun(overrun), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic push_expected();
        logic [31:0] w;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_ovr = 1'b1;
        for (int a = 0; a < 32; a++) begin
            w = model[a];
            exp_addr_q.push_back(5'(a));
            exp_data_q.push_back(w);
            if (w[31:24] == 8'hFF) begin
                exp_ovr = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_start(input string name, input bit wr_same, input logic [31:0] wd);
        push_expected();
        start = 1'b1;
        if (wr_same) begin
            wr_en = 1'b1; wr_addr = 5'd0; wr_data = wd;
        end
        tick();
        start = 1'b0;
        if (wr_same) begin
            wr_en = 1'b0;
            model[0] = wd;
        end
        checks++;
        if (busy !== 1'b1 || instr_valid !== 1'b0)
            $display("FAIL %s_prime busy=%b valid=%b required busy=1 valid=0", name, busy, instr_valid);
        if (busy !== 1'b1 || instr_valid !== 1'b0) failures++;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_addr !== 5'd0) begin
            $display("FAIL %s_first valid=%b addr=%0d required valid=1 addr=0", name, instr_valid, instr_addr);
            failures++;
        end
    endtask

    task automatic run_stream(input string name, input int stall_addr, input int stall_n, input bit inject);
        int accepts = 0;
        int stalled = 0;
        int pres = 0;
        int exp_n;
        bit done_seen = 1'b0;
        exp_n = exp_addr_q.size();
        for (int c = 0; c < 200 && !done_seen; c++) begin
            start = 1'b0;
            wr_en = 1'b0;
            if (inject && c == 1) begin
                wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF; start = 1'b1;
            end
            if (inject && c == 2) start = 1'b1;
            instr_ready = 1'b1;
            if (instr_valid === 1'b1) begin
                if (int'(instr_addr) == stall_addr) pres++;
                if (exp_addr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL %s_extra addr=%0d data=%h required no further word", name, instr_addr, instr_data);
                end else begin
                    checks++;
                    if (instr_addr !== exp_addr_q[0] || instr_data !== exp_data_q[0]) begin
                        failures++;
                        $display("FAIL %s_word addr=%0d data=%h required addr=%0d data=%h",
                                 name, instr_addr, instr_data, exp_addr_q[0], exp_data_q[0]);
                    end
                    if (int'(instr_addr) == stall_addr && stalled < stall_n) begin
                        instr_ready = 1'b0;
                        stalled++;
                    end else begin
                        void'(exp_addr_q.pop_front());
                        void'(exp_data_q.pop_front());
                        accepts++;
                    end
                end
            end
            tick();
            if (inject && c == 1) begin
                checks++;
                if (wr_err !== PROT) begin
                    failures++;
                    $display("FAIL %s_wr_err got=%b required=%b", name, wr_err, PROT);
                end
                if (!PROT) model[3] = 32'hDEADBEEF;
            end
            if (done === 1'b1) begin
                done_seen = 1'b1;
                checks++;
                if (overrun !== exp_ovr || busy !== 1'b0 || instr_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_end overrun=%b busy=%b valid=%b required overrun=%b busy=0 valid=0",
                             name, overrun, busy, instr_valid, exp_ovr);
                end
            end
        end
        start = 1'b0; wr_en = 1'b0; instr_ready = 1'b1;
        checks++;
        if (!done_seen || accepts != exp_n) begin
            failures++;
            $display("FAIL %s_count done_seen=%0d accepts=%0d required done_seen=1 accepts=%0d", name, done_seen, accepts, exp_n);
        end
        if (stall_n > 0) begin
            checks++;
            if (pres != stall_n + 1) begin
                failures++;
                $display("FAIL %s_hold cycles=%0d required=%0d", name, pres, stall_n + 1);
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL %s_after done=%b busy=%b valid=%b overrun=%b required all 0", name, done, busy, instr_valid, overrun);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b0 || instr_data !== 32'd0 || instr_addr !== 5'd0 || busy !== 1'b0 ||
            done !== 1'b0 || overrun !== 1'b0 || wr_err !== 1'b0) begin
            failures++;
            $display("FAIL reset valid=%b data=%h addr=%0d busy=%b done=%b ovr=%b wr_err=%b required all 0",
                     instr_valid, instr_data, instr_addr, busy, done, overrun, wr_err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        write_word(5'd0, 32'h01000010);
        write_word(5'd1, 32'h02000020);
        write_word(5'd2, 32'hFF000000);
        write_word(5'd3, 32'h04000040);
        do_start("basic", 1'b0, 32'd0);
        run_stream("basic", -1, 0, 1'b0);
    endtask

    task automatic test_stall();
        do_start("stall", 1'b0, 32'd0);
        run_stream("stall", 1, 3, 1'b0);
    endtask

    task automatic test_write_during_run();
        do_start("wrrun", 1'b0, 32'd0);
        run_stream("wrrun", -1, 0, 1'b1);
        write_word(5'd2, 32'h03000030);
        write_word(5'd4, 32'hFF0000AA);
        do_start("wrchk", 1'b0, 32'd0);
        run_stream("wrchk", -1, 0, 1'b0);
    endtask

    task automatic test_read_first();
        do_start("rdfirst", 1'b1, 32'h05000050);
        run_stream("rdfirst", -1, 0, 1'b0);
        do_start("rdnew", 1'b0, 32'd0);
        run_stream("rdnew", -1, 0, 1'b0);
    endtask

    task automatic test_overrun();
        for (int a = 0; a < 32; a++) write_word(5'(a), 32'h00000001);
        do_start("ovr", 1'b0, 32'd0);
        run_stream("ovr", -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        bit hit = 1'b0;
        bit early_done = 1'b0;
        do_start("midrst", 1'b0, 32'd0);
        instr_ready = 1'b1;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (instr_valid === 1'b1 && instr_addr === 5'd5) hit = 1'b1;
            else begin
                tick();
                if (done === 1'b1) early_done = 1'b1;
            end
        end
        checks++;
        if (!hit || early_done) begin
            failures++;
            $display("FAIL midrst_reach hit=%0d early_done=%0d required hit=1 early_done=0", hit, early_done);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instr_data !== 32'd0 || instr_addr !== 5'd0 || busy !== 1'b0 ||
            done !== 1'b0 || overrun !== 1'b0 || wr_err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs valid=%b data=%h addr=%0d busy=%b done=%b required all 0",
                     instr_valid, instr_data, instr_addr, busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_nodone done=%b busy=%b required 0 0", done, busy);
        end
        do_start("replay", 1'b0, 32'd0);
        run_stream("replay", -1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_write_during_run();
        test_read_first();
        test_overrun();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
